// File: rtl/reg_dump_reader_pkg.sv
// Shared constants and state encoding for the register-dump reader.
package reg_dump_reader_pkg;

    localparam int BYTE_WIDTH         = 8;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / BYTE_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Number of stream bytes carried by one register word.
    function automatic int bytes_per_word(input int data_width);
        return data_width / BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/reg_dump_reader_if.sv
// Register-file read port plus byte stream toward the debug UART transmitter.
// Signal names are written from the reader's point of view.
import reg_dump_reader_pkg::*;

interface reg_dump_reader_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int P_REG_WIDTH = 5
);
    logic [P_REG_WIDTH-1:0] o_reg_addr;
    logic                   o_reg_read;
    logic [DATA_WIDTH-1:0]  i_reg_data;
    logic [BYTE_WIDTH-1:0]  o_byte;
    logic                   o_byte_valid;
    logic                   i_byte_ready;

    // The reader drives addresses and stream data.
    modport master (
        output o_reg_addr, o_reg_read, o_byte, o_byte_valid,
        input  i_reg_data, i_byte_ready
    );

    // Register file and UART side.
    modport slave (
        input  o_reg_addr, o_reg_read, o_byte, o_byte_valid,
        output i_reg_data, i_byte_ready
    );
endinterface

// File: rtl/reg_dump_reader_word_byte_serializer.sv
// Splits one loaded word into bytes, least significant byte first, over a
// valid/ready stream. o_last marks the transfer of the final byte.
import reg_dump_reader_pkg::*;

module word_byte_serializer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic                  i_ready,
    output logic [BYTE_WIDTH-1:0] o_byte,
    output logic                  o_valid,
    output logic                  o_last
);
    localparam int BPW   = bytes_per_word(DATA_WIDTH);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_count;
    logic                  r_valid;
    logic                  w_xfer;

    assign w_xfer  = r_valid && i_ready;
    assign o_last  = w_xfer && (r_count == CNT_W'(BPW - 1));
    assign o_valid = r_valid;
    assign o_byte  = r_valid ? r_shift[BYTE_WIDTH-1:0] : '0;

    // Load a word, then shift out one byte per accepted transfer.
    // NOTE: the shift register is reset too, because o_byte must read zero
    // during reset; everything here is state, so only <= is used.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_count <= '0;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            r_shift <= r_shift >> BYTE_WIDTH;
            if (o_last) begin
                r_count <= '0;
                r_valid <= 1'b0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/reg_dump_reader.sv
// Walks register addresses 0..NUM_REGS-1 through the register file read port
// and streams every word out as bytes toward the debug UART.
import reg_dump_reader_pkg::*;

module reg_dump_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int P_REG_WIDTH  = 5,
    parameter int NUM_REGS     = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    reg_dump_reader_if.master bus
);
    localparam int                   LAT_W      = $clog2(READ_LATENCY + 1);
    localparam [P_REG_WIDTH-1:0]     LAST_INDEX = P_REG_WIDTH'(NUM_REGS - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [P_REG_WIDTH-1:0] r_index;
    logic [LAT_W-1:0]       r_lat;
    logic                   w_abort;
    logic                   w_load;
    logic                   w_last;

    // Abort only means something while a dump is in progress.
    assign w_abort = i_abort && (r_state != ST_IDLE);
    // Capture on the edge that ends the final WAIT cycle.
    assign w_load  = (r_state == ST_WAIT) && (r_lat == LAT_W'(1)) && !i_abort;

    assign o_busy          = (r_state != ST_IDLE);
    assign o_done          = (r_state == ST_DONE);
    assign bus.o_reg_read  = (r_state == ST_REQ);
    assign bus.o_reg_addr  = r_index;

    word_byte_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_clear (w_abort),
        .i_word  (bus.i_reg_data),
        .i_ready (bus.i_byte_ready),
        .o_byte  (bus.o_byte),
        .o_valid (bus.o_byte_valid),
        .o_last  (w_last)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; abort overrides every other transition.
    // NOTE: w_next gets its default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (i_start) w_next = ST_REQ;
            ST_REQ:  w_next = ST_WAIT;
            ST_WAIT: if (r_lat == LAT_W'(1)) w_next = ST_SEND;
            ST_SEND: if (w_last) w_next = (r_index == LAST_INDEX) ? ST_DONE : ST_REQ;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (w_abort) begin
            w_next = ST_IDLE;
        end
    end

    // Register index and read-latency counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_index <= '0;
            r_lat   <= '0;
        end else if (w_abort) begin
            r_index <= '0;
            r_lat   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_index <= '0;
                    r_lat   <= '0;
                end
                ST_REQ:  r_lat <= LAT_W'(READ_LATENCY);
                ST_WAIT: r_lat <= r_lat - LAT_W'(1);
                ST_SEND: begin
                    if (w_last && (r_index != LAST_INDEX)) begin
                        r_index <= r_index + P_REG_WIDTH'(1);
                    end
                end
                ST_DONE: r_index <= '0;
                default: begin
                    r_index <= '0;
                    r_lat   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: two instances (read latency 1 and 3), a
// register-file model with exact latency, and a queue model of the expected
// address and byte sequences for each dump.
module tb_reg_dump_reader;
    import reg_dump_reader_pkg::*;

    localparam int NUM = 32;
    localparam int BPW = 4;
    localparam int RL0 = 1;
    localparam int RL1 = 3;

    logic clk = 1'b0;
    logic rst;
    logic start0, abort0, busy0, done0;
    logic start1, abort1, busy1, done1;

    reg_dump_reader_if #(.DATA_WIDTH(32), .P_REG_WIDTH(5)) b0 ();
    reg_dump_reader_if #(.DATA_WIDTH(32), .P_REG_WIDTH(5)) b1 ();

    reg_dump_reader #(.DATA_WIDTH(32), .P_REG_WIDTH(5), .NUM_REGS(NUM), .READ_LATENCY(RL0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_start(start0), .i_abort(abort0),
        .o_busy(busy0), .o_done(done0), .bus(b0)
    );
    reg_dump_reader #(.DATA_WIDTH(32), .P_REG_WIDTH(5), .NUM_REGS(NUM), .READ_LATENCY(RL1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_start(start1), .i_abort(abort1),
        .o_busy(busy1), .o_done(done1), .bus(b1)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int total = 0;
    int bad   = 0;

    logic [31:0] regs [NUM];
    int          rmode [2];          // 0: ready high, 1: random, 2: manual
    logic [7:0]  eb [2][0:NUM*BPW-1];
    int          ebh [2], ebt [2];
    int          ea [2][0:NUM-1];
    int          eah [2], eat [2];
    int          done_cnt [2], done_cyc [2], start_cyc [2], xfer_cnt [2], last_rd [2];
    bit          spacing_en [2];
    logic [7:0]  log0 [0:NUM*BPW-1];
    logic        pv0 [4], pv1 [4];
    logic [4:0]  pa0 [4], pa1 [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load_model(input int id);
        for (int n = 0; n < NUM; n++) begin
            ea[id][n] = n;
            for (int b = 0; b < BPW; b++) eb[id][n*BPW+b] = 8'(regs[n] >> (8*b));
        end
        eah[id] = 0; eat[id] = NUM;
        ebh[id] = 0; ebt[id] = NUM*BPW;
        xfer_cnt[id] = 0;
        last_rd[id]  = -1;
    endtask

    task automatic clear_model(input int id);
        eah[id] = 0; eat[id] = 0;
        ebh[id] = 0; ebt[id] = 0;
    endtask

    task automatic rand_regs();
        for (int n = 0; n < NUM; n++) regs[n] = (n == 0) ? 32'h0 : $urandom();
    endtask

    // Compare one instance's outputs against the expected sequences.
    task automatic mon(input int id, input logic rd, input logic [4:0] addr, input logic v,
                       input logic [7:0] by, input logic rdy, input logic dn, input logic bsy);
        int rl;
        rl = (id == 0) ? RL0 : RL1;
        if (rd) begin
            check($sformatf("rd_expected%0d", id), 32'(eah[id] < eat[id]), 32'd1);
            if (eah[id] < eat[id]) begin
                check($sformatf("rd_addr%0d", id), 32'(addr), ea[id][eah[id]]);
                eah[id]++;
            end
            if (spacing_en[id] && last_rd[id] >= 0)
                check($sformatf("rd_spacing%0d", id), cyc - last_rd[id], 1 + rl + BPW);
            last_rd[id] = cyc;
        end
        if (v) begin
            check($sformatf("valid_busy%0d", id), 32'(bsy), 32'd1);
            check($sformatf("byte_expected%0d", id), 32'(ebh[id] < ebt[id]), 32'd1);
            if (ebh[id] < ebt[id]) begin
                check($sformatf("byte%0d", id), 32'(by), 32'(eb[id][ebh[id]]));
                if (rdy) begin
                    if (id == 0) log0[ebh[id]] = by;
                    ebh[id]++;
                    xfer_cnt[id]++;
                end
            end
        end
        if (dn) begin
            done_cnt[id]++;
            done_cyc[id] = cyc;
            check($sformatf("done_drained%0d", id), (ebt[id]-ebh[id]) + (eat[id]-eah[id]), 0);
        end
        if (!bsy) check($sformatf("idle_quiet%0d", id), 32'({v, rd, dn}), 32'd0);
    endtask

    // Single compare process, sampling on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            mon(0, b0.o_reg_read, b0.o_reg_addr, b0.o_byte_valid, b0.o_byte, b0.i_byte_ready, done0, busy0);
            mon(1, b1.o_reg_read, b1.o_reg_addr, b1.o_byte_valid, b1.o_byte, b1.i_byte_ready, done1, busy1);
        end
    end

    // Register-file models with exact read latency (garbage otherwise) and ready drivers.
    initial begin
        logic       rd0_s, rd1_s;
        logic [4:0] ad0_s, ad1_s;
        for (int k = 0; k < 4; k++) begin
            pv0[k] = 1'b0; pv1[k] = 1'b0; pa0[k] = '0; pa1[k] = '0;
        end
        forever begin
            @(negedge clk);
            rd0_s = b0.o_reg_read; ad0_s = b0.o_reg_addr;
            rd1_s = b1.o_reg_read; ad1_s = b1.o_reg_addr;
            @(posedge clk);
            #1;
            for (int k = 3; k > 0; k--) begin
                pv0[k] = pv0[k-1]; pa0[k] = pa0[k-1];
                pv1[k] = pv1[k-1]; pa1[k] = pa1[k-1];
            end
            pv0[0] = rd0_s; pa0[0] = ad0_s;
            pv1[0] = rd1_s; pa1[0] = ad1_s;
            b0.i_reg_data = pv0[RL0-1] ? regs[pa0[RL0-1]] : $urandom();
            b1.i_reg_data = pv1[RL1-1] ? regs[pa1[RL1-1]] : $urandom();
            if (rmode[0] == 0) b0.i_byte_ready = 1'b1;
            else if (rmode[0] == 1) b0.i_byte_ready = ($urandom_range(0, 3) != 0);
            if (rmode[1] == 0) b1.i_byte_ready = 1'b1;
            else if (rmode[1] == 1) b1.i_byte_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the REQ cycle.
    task automatic start_dump(input int id);
        load_model(id);
        start_cyc[id] = cyc + 1;
        if (id == 0) start0 = 1'b1; else start1 = 1'b1;
        step(1);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_until(input int id, input int k);
        while (cyc < start_cyc[id] + k) step(1);
    endtask

    task automatic wait_done(input int id, input int budget);
        int d0;
        int k;
        d0 = done_cnt[id];
        k  = 0;
        while (done_cnt[id] == d0 && k < budget) begin
            step(1);
            k++;
        end
        check($sformatf("done_seen%0d", id), done_cnt[id] - d0, 1);
        step(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int dc;
        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        rmode[0] = 0; rmode[1] = 0;
        b0.i_byte_ready = 1'b1; b1.i_byte_ready = 1'b1;
        b0.i_reg_data = '0; b1.i_reg_data = '0;
        for (int i = 0; i < 2; i++) begin
            clear_model(i);
            done_cnt[i] = 0; done_cyc[i] = 0; start_cyc[i] = 0;
            xfer_cnt[i] = 0; last_rd[i] = -1; spacing_en[i] = 1'b0;
        end
        #2;
        check("reset_outs0", 32'({b0.o_reg_addr, b0.o_reg_read, b0.o_byte, b0.o_byte_valid, busy0, done0}), 32'd0);
        check("reset_outs1", 32'({b1.o_reg_addr, b1.o_reg_read, b1.o_byte, b1.o_byte_valid, busy1, done1}), 32'd0);
        step(1);
        rst = 1'b0;
        step(2);

        // Full dump with the A0000000|n pattern and ready held high.
        for (int n = 0; n < NUM; n++) regs[n] = (n == 0) ? 32'h0 : (32'hA000_0000 | 32'(n));
        spacing_en[0] = 1'b1;
        start_dump(0);
        wait_done(0, 400);
        check("t1_bytes", xfer_cnt[0], 128);
        check("t1_b20", 32'(log0[20]), 32'h05);
        check("t1_b21", 32'(log0[21]), 32'h00);
        check("t1_b22", 32'(log0[22]), 32'h00);
        check("t1_b23", 32'(log0[23]), 32'hA0);
        // REQ of reg 0 is the first cycle after the start edge; DONE is the 193rd.
        check("t1_done_cycle", done_cyc[0] - start_cyc[0] + 1, 193);

        // Backpressure: byte 2 of reg 7 (stream byte 30) is presented 46 cycles in.
        spacing_en[0] = 1'b0;
        rmode[0] = 2;
        start_dump(0);
        wait_until(0, 46);
        b0.i_byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_hold_byte", 32'(b0.o_byte), 32'h00);
            check("t2_hold_valid", 32'(b0.o_byte_valid), 32'd1);
            check("t2_hold_count", xfer_cnt[0], 30);
            step(1);
        end
        b0.i_byte_ready = 1'b1;
        wait_done(0, 400);
        check("t2_bytes", xfer_cnt[0], 128);
        check("t2_done_cycle", done_cyc[0] - start_cyc[0] + 1, 196);

        // Start pulse while busy is ignored.
        rmode[0] = 0;
        spacing_en[0] = 1'b1;
        rand_regs();
        dc = done_cnt[0];
        start_dump(0);
        wait_until(0, 50);
        start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        wait_done(0, 400);
        step(12);
        check("t3_single_done", done_cnt[0] - dc, 1);
        check("t3_idle", 32'(busy0), 32'd0);
        check("t3_bytes", xfer_cnt[0], 128);

        // Abort during SEND of reg 10 (cycles 62..65), then restart.
        rand_regs();
        dc = done_cnt[0];
        start_dump(0);
        wait_until(0, 63);
        abort0 = 1'b1;
        step(1);
        abort0 = 1'b0;
        clear_model(0);
        @(negedge clk);
        check("t4_valid", 32'(b0.o_byte_valid), 32'd0);
        check("t4_busy", 32'(busy0), 32'd0);
        step(6);
        check("t4_no_done", done_cnt[0] - dc, 0);
        spacing_en[0] = 1'b0;
        rmode[0] = 1;
        rand_regs();
        start_dump(0);
        @(negedge clk);
        check("t4_restart", 32'({b0.o_reg_read, b0.o_reg_addr}), 32'h20);
        wait_done(0, 2000);
        check("t4_bytes", xfer_cnt[0], 128);

        // Asynchronous reset in WAIT of reg 3 (cycle 19).
        rmode[0] = 0;
        rand_regs();
        dc = done_cnt[0];
        start_dump(0);
        wait_until(0, 19);
        check("t5_busy_before", 32'(busy0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_outs", 32'({b0.o_reg_addr, b0.o_reg_read, b0.o_byte, b0.o_byte_valid, busy0, done0}), 32'd0);
        clear_model(0);
        step(2);
        rst = 1'b0;
        step(10);
        check("t5_stays_idle", 32'(busy0), 32'd0);
        check("t5_no_done", done_cnt[0] - dc, 0);
        rmode[0] = 1;
        rand_regs();
        start_dump(0);
        wait_done(0, 2000);
        check("t5_bytes", xfer_cnt[0], 128);

        // A few more randomized dumps with random backpressure.
        for (int s = 0; s < 3; s++) begin
            rand_regs();
            start_dump(0);
            wait_done(0, 2000);
            check("rand_bytes", xfer_cnt[0], 128);
        end

        // Read latency 3: eight cycles per register with ready high.
        rmode[0] = 0;
        rmode[1] = 0;
        spacing_en[1] = 1'b1;
        rand_regs();
        start_dump(1);
        wait_done(1, 600);
        check("t6_bytes", xfer_cnt[1], 128);
        check("t6_done_cycle", done_cyc[1] - start_cyc[1] + 1, 257);
        spacing_en[1] = 1'b0;
        rmode[1] = 1;
        rand_regs();
        start_dump(1);
        wait_done(1, 3000);
        check("t6_rand_bytes", xfer_cnt[1], 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
